// File: rtl/fir_requant_decim.sv
// Requantizes full-precision FIR samples (round half-up, saturate) and decimates them.
// Kept samples pass through one register stage into a 2-entry output FIFO with valid/ready.
module fir_requant_decim #(
    parameter int NB_DATA = 19,
    parameter int NB_OUT  = 8,
    parameter int SHIFT   = 7
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic signed [NB_DATA-1:0] i_data,
    input  logic                      i_enable,
    input  logic [3:0]                i_decim,
    input  logic                      i_ready,
    output logic signed [NB_OUT-1:0]  o_data,
    output logic                      o_valid,
    output logic                      o_sat,
    output logic [15:0]               o_drop_count
);

    localparam int W_EXT = NB_DATA + 1;
    localparam logic signed [W_EXT-1:0] HALF    = W_EXT'(1 << (SHIFT - 1));
    localparam logic signed [W_EXT-1:0] SAT_MAX = W_EXT'((1 << (NB_OUT - 1)) - 1);
    localparam logic signed [W_EXT-1:0] SAT_MIN = W_EXT'(-(1 << (NB_OUT - 1)));

    logic [3:0]               r_phase;
    logic [3:0]               r_factor_m1;
    logic                     r_load;
    logic                     r_s1_valid;
    logic signed [NB_OUT-1:0] r_s1_data;
    logic                     r_sat;
    logic signed [NB_OUT-1:0] r_mem [2];
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic [15:0]              r_drop;

    logic [3:0]               w_factor_m1;
    logic                     w_keep;
    logic                     w_wrap;
    logic signed [W_EXT-1:0]  w_sum;
    logic signed [W_EXT-1:0]  w_round;
    logic                     w_over;
    logic                     w_under;
    logic signed [NB_OUT-1:0] w_q;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_push;
    logic                     w_drop;

    // First edge after reset release uses the live i_decim, which is also latched then.
    assign w_factor_m1 = r_load ? i_decim : r_factor_m1;
    assign w_keep      = i_enable && i_valid && (r_phase == 4'd0);
    assign w_wrap      = i_enable && i_valid && (r_phase == w_factor_m1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_phase     <= 4'd0;
            r_factor_m1 <= 4'd0;
            r_load      <= 1'b1;
        end else begin
            r_load <= 1'b0;
            if (!i_enable || w_wrap) begin
                r_phase     <= 4'd0;
                r_factor_m1 <= i_decim;
            end else begin
                if (i_valid) r_phase <= r_phase + 4'd1;
                if (r_load)  r_factor_m1 <= i_decim;
            end
        end
    end

    // One guard bit above the input keeps the rounding add from overflowing.
    assign w_sum   = W_EXT'(i_data) + HALF;
    assign w_round = w_sum >>> SHIFT;
    assign w_over  = (w_round > SAT_MAX);
    assign w_under = (w_round < SAT_MIN);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_q = w_round[NB_OUT-1:0];
        if (w_over)       w_q = SAT_MAX[NB_OUT-1:0];
        else if (w_under) w_q = SAT_MIN[NB_OUT-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
            r_sat      <= w_keep && (w_over || w_under);
            if (w_keep) r_s1_data <= w_q;
        end
    end

    assign w_pop  = (r_count != 2'd0) && i_ready;
    assign w_full = (r_count == 2'd2);
    assign w_push = r_s1_valid && (!w_full || w_pop);
    assign w_drop = r_s1_valid && w_full && !w_pop;

    // NOTE: the two FIFO entries are reset so o_data reads 0, never X, after reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_drop   <= 16'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_s1_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
    end

    assign o_data       = r_mem[r_rd_ptr];
    assign o_valid      = (r_count != 2'd0);
    assign o_sat        = r_sat;
    assign o_drop_count = r_drop;

endmodule

// File: tb/tb_fir_requant_decim.sv
// Bench for fir_requant_decim: directed table, multi-cycle corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_fir_requant_decim;

    localparam int NB_DATA = 19;
    localparam int NB_OUT  = 8;
    localparam int SHIFT   = 7;
    localparam int OUT_MAX = (1 << (NB_OUT - 1)) - 1;
    localparam int OUT_MIN = -(1 << (NB_OUT - 1));

    logic                      i_clock = 1'b0;
    logic                      i_reset;
    logic                      i_valid;
    logic signed [NB_DATA-1:0] i_data;
    logic                      i_enable;
    logic [3:0]                i_decim;
    logic                      i_ready;
    logic signed [NB_OUT-1:0]  o_data;
    logic                      o_valid;
    logic                      o_sat;
    logic [15:0]               o_drop_count;

    fir_requant_decim #(.NB_DATA(NB_DATA), .NB_OUT(NB_OUT), .SHIFT(SHIFT)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_enable     (i_enable),
        .i_decim      (i_decim),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_sat        (o_sat),
        .o_drop_count (o_drop_count)
    );

    always #5 i_clock = ~i_clock;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic rounding, phase counting modulo factor, FIFO as a queue.
    int m_phase;
    int m_factor;
    bit m_s1_v;
    int m_s1_val;
    bit m_sat;
    int m_drop;
    int m_fifo[$];
    int got[$];

    function automatic int requant(input int d, output bit sat);
        int t;
        int r;
        t = d + (1 << (SHIFT - 1));
        if (t >= 0) r = t / (1 << SHIFT);
        else        r = -((-t + (1 << SHIFT) - 1) / (1 << SHIFT));
        sat = 1'b0;
        if (r > OUT_MAX) begin r = OUT_MAX; sat = 1'b1; end
        if (r < OUT_MIN) begin r = OUT_MIN; sat = 1'b1; end
        return r;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_factor = int'(i_decim) + 1;
        m_s1_v   = 1'b0;
        m_s1_val = 0;
        m_sat    = 1'b0;
        m_drop   = 0;
        m_fifo.delete();
    endtask

    task automatic model_edge();
        bit pop;
        bit full;
        bit keep;
        bit s;
        if (i_reset) begin
            model_reset();
        end else begin
            pop  = (m_fifo.size() > 0) && i_ready;
            full = (m_fifo.size() == 2);
            if (pop) void'(m_fifo.pop_front());
            if (m_s1_v) begin
                if (!full || pop) m_fifo.push_back(m_s1_val);
                else if (m_drop < 65535) m_drop++;
            end
            keep   = i_enable && i_valid && (m_phase == 0);
            m_s1_v = keep;
            s      = 1'b0;
            if (keep) m_s1_val = requant(int'(i_data), s);
            m_sat = keep && s;
            if (!i_enable) begin
                m_phase  = 0;
                m_factor = int'(i_decim) + 1;
            end else if (i_valid) begin
                m_phase = (m_phase + 1) % m_factor;
                if (m_phase == 0) m_factor = int'(i_decim) + 1;
            end
        end
    endtask

    // One clock: record any transfer, advance model on the edge, compare 1 time unit later.
    task automatic cycle();
        if (o_valid && i_ready) got.push_back(int'(o_data));
        @(posedge i_clock);
        model_edge();
        #1;
        check("o_valid", o_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check("o_data", o_data, m_fifo[0]);
        else                   check("o_data_known", $isunknown(o_data), 0);
        check("o_sat", o_sat, m_sat);
        check("o_drop_count", o_drop_count, m_drop);
    endtask

    task automatic do_reset(input logic [3:0] decim);
        i_decim = decim;
        i_valid = 1'b0;
        i_reset = 1'b1;
        #1;
        model_reset();
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_sat", o_sat, 0);
        check("rst_o_drop_count", o_drop_count, 0);
        cycle();
        i_reset = 1'b0;
        cycle();
        got.delete();
    endtask

    task automatic feed(input int d);
        i_valid = 1'b1;
        i_data  = NB_DATA'(d);
        cycle();
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    typedef struct {
        int din;
        int dout;
        bit sat;
    } vec_t;

    vec_t tbl[13];
    int   exp_ramp[4];
    int   exp_chg[5];

    initial begin
        tbl[0]  = '{1000, 8, 1'b0};
        tbl[1]  = '{192, 2, 1'b0};
        tbl[2]  = '{64, 1, 1'b0};
        tbl[3]  = '{-64, 0, 1'b0};
        tbl[4]  = '{-1000, -8, 1'b0};
        tbl[5]  = '{262143, 127, 1'b1};
        tbl[6]  = '{-262144, -128, 1'b1};
        tbl[7]  = '{63, 0, 1'b0};
        tbl[8]  = '{-65, -1, 1'b0};
        tbl[9]  = '{16256, 127, 1'b0};
        tbl[10] = '{16320, 127, 1'b1};
        tbl[11] = '{-16448, -128, 1'b0};
        tbl[12] = '{-16449, -128, 1'b1};
        exp_ramp = '{0, 4, 8, 12};
        exp_chg  = '{0, 4, 6, 8, 10};

        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_enable = 1'b1;
        i_decim  = 4'd0;
        i_ready  = 1'b1;

        // Directed table: factor 1, always ready; o_sat right after the edge, data one edge later.
        do_reset(4'd0);
        for (int i = 0; i < 13; i++) begin
            feed(tbl[i].din);
            check("tbl_sat", o_sat, tbl[i].sat);
            if (i == 0) begin
                check("tbl_first_latency", o_valid, 0);
            end else begin
                check("tbl_valid", o_valid, 1);
                check("tbl_data", o_data, tbl[i-1].dout);
            end
        end
        idle(1);
        check("tbl_valid_last", o_valid, 1);
        check("tbl_data_last", o_data, tbl[12].dout);
        idle(2);
        check("tbl_drained", o_valid, 0);

        // Decimate by 4 on a ramp.
        do_reset(4'd3);
        for (int n = 0; n < 16; n++) feed(128 * n);
        idle(4);
        check("ramp_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) check("ramp_data", got[k], exp_ramp[k]);

        // Backpressure: third kept sample is dropped, then the buffered two drain in order.
        do_reset(4'd0);
        i_ready = 1'b0;
        feed(128); feed(256); feed(384);
        idle(2);
        check("bp_drop", o_drop_count, 1);
        check("bp_valid", o_valid, 1);
        check("bp_head", o_data, 1);
        i_ready = 1'b1;
        idle(1);
        check("bp_second_valid", o_valid, 1);
        check("bp_second", o_data, 2);
        idle(1);
        check("bp_empty", o_valid, 0);

        // Factor change mid-period only applies after the wrap.
        do_reset(4'd3);
        for (int n = 0; n < 11; n++) begin
            if (n == 2) i_decim = 4'd1;
            feed(128 * n);
        end
        idle(4);
        check("chg_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) check("chg_data", got[k], exp_chg[k]);

        // Enable low discards input and restarts the phase, buffered data still drains.
        do_reset(4'd2);
        feed(256);
        i_enable = 1'b0;
        feed(512); feed(768);
        i_enable = 1'b1;
        feed(1024);
        idle(4);
        check("en_count", got.size(), 2);
        if (got.size() == 2) begin
            check("en_first", got[0], 2);
            check("en_second", got[1], 8);
        end

        // Mid-operation reset with a full FIFO and five drops.
        do_reset(4'd0);
        i_ready = 1'b0;
        for (int n = 1; n <= 7; n++) feed(128 * n);
        idle(2);
        check("pre_rst_drop", o_drop_count, 5);
        check("pre_rst_valid", o_valid, 1);
        do_reset(4'd0);
        i_ready = 1'b1;
        feed(640);
        check("post_rst_latency", o_valid, 0);
        idle(1);
        check("post_rst_valid", o_valid, 1);
        check("post_rst_data", o_data, 5);

        // Randomized traffic against the model.
        do_reset(4'($urandom));
        for (int c = 0; c < 3000; c++) begin
            i_valid  = ($urandom % 4) != 0;
            i_enable = ($urandom % 16) != 0;
            i_ready  = ($urandom % 3) != 0;
            if (($urandom % 50) == 0) i_decim = 4'($urandom);
            if (($urandom % 2) == 0) i_data = NB_DATA'($urandom);
            else i_data = NB_DATA'(int'($urandom_range(32767, 0)) - 16384);
            if (($urandom % 600) == 0) do_reset(i_decim);
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fir_requant_decim.md
FIR_REQUANT_DECIM -- requirements
Module: fir_requant_decim

Interface
REQ-001 Parameter NB_DATA, default 19, width of the signed full-precision FIR result consumed from fir_serial_parallel (8+8+3).
REQ-002 Parameter NB_OUT, default 8, width of the signed requantized output sample.
REQ-003 Parameter SHIFT, default 7, number of LSBs discarded by rounding; legal range 1..NB_DATA-NB_OUT.
REQ-004 i_clock  in  1  single clock; all state updates on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_valid  in  1  i_data holds a valid FIR sample this cycle (upstream cannot stall).
REQ-007 i_data  in  NB_DATA  signed two's-complement FIR output.
REQ-008 i_enable  in  1  block enable; low holds phase at 0 and discards input.
REQ-009 i_decim  in  4  decimation factor minus one (factor = i_decim+1, 1..16).
REQ-010 i_ready  in  1  downstream accepts o_data when high with o_valid.
REQ-011 o_data  out  NB_OUT  signed rounded/saturated decimated sample (head of output FIFO).
REQ-012 o_valid  out  1  o_data valid; transfer occurs on edge with o_valid && i_ready.
REQ-013 o_sat  out  1  one-cycle pulse: the sample just registered in stage 1 was saturated.
REQ-014 o_drop_count  out  16  count of kept samples lost to a full FIFO; saturates at 0xFFFF.

Function
REQ-015 Phase counter SHALL increment modulo factor on every edge with i_valid && i_enable; a sample SHALL be kept when phase == 0 before the increment.
REQ-016 Factor SHALL be latched from i_decim at reset release, while i_enable is low, and each time phase wraps to 0; mid-period changes of i_decim SHALL take effect only at the next wrap.
REQ-017 i_enable low SHALL force phase to 0 on the next edge; stage-1 and FIFO contents SHALL be preserved and continue to drain.
REQ-018 Rounding: r = (i_data + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round-half-up toward +inf), computed at NB_DATA+1 bits with no intermediate overflow.
REQ-019 Saturation: r > 2^(NB_OUT-1)-1 SHALL yield 2^(NB_OUT-1)-1; r < -2^(NB_OUT-1) SHALL yield -2^(NB_OUT-1); o_sat SHALL pulse high for the cycle following the edge that registered that sample.
REQ-020 Stage 1 SHALL register the rounded/saturated value and a valid bit on the edge a kept sample is sampled (edge k).
REQ-021 Output buffer SHALL be a 2-entry FIFO written from stage 1 on edge k+1; o_valid SHALL be high after edge k+1 when the FIFO was empty (2-cycle latency input-to-o_valid).
REQ-022 o_data SHALL be stable and o_valid SHALL stay high while o_valid && !i_ready (no sample loss once buffered).
REQ-023 FIFO full with simultaneous pop (o_valid && i_ready) and stage-1 write SHALL accept the write; occupancy stays 2.
REQ-024 FIFO full, no pop, stage-1 valid: sample SHALL be dropped, FIFO unchanged, o_drop_count incremented (held at 0xFFFF once reached).
REQ-025 FIFO empty with no stage-1 write SHALL leave o_valid low; o_data value is don't-care when o_valid low but SHALL not be X after reset.
REQ-026 Samples SHALL leave the FIFO in arrival order.

Reset
REQ-027 While i_reset high: phase=0, stage-1 valid=0, FIFO empty, o_valid=0, o_data=0, o_sat=0, o_drop_count=0, factor latched from i_decim.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately (asynchronously) and discard buffered samples; first kept sample after release SHALL be the first i_valid sample with i_enable high.

Verification
REQ-029 i_decim=0, i_ready=1, i_data=1000,192,64,-64,-1000 on consecutive cycles -> o_data 8,2,1,0,-8, each 2 cycles after input, o_sat never high.
REQ-030 i_decim=0, i_data=262143 then -262144 -> o_data 127 then -128, o_sat pulses once per sample.
REQ-031 i_decim=3, i_data ramp 0,128,256,... (sample n = 128n) continuous -> o_data 0,4,8,12,... (n=0,4,8,12 kept).
REQ-032 i_decim=0, i_ready=0, three kept samples 128,256,384 -> FIFO holds 1,2; o_drop_count=1; raise i_ready -> outputs 1 then 2, o_valid falls.
REQ-033 i_decim=3, change i_decim to 1 at phase 2 -> next kept sample after wrap is 4 inputs later, thereafter every 2 inputs.
REQ-034 Assert i_reset for one cycle with FIFO holding 2 samples and o_drop_count=5 -> o_valid=0, o_drop_count=0 immediately; next output is first post-reset input.
